// File: rtl/calc_pkg.sv
// Shared constants and types for the BCD calculator controller.
package calc_pkg;

  localparam int NDIG_DEF = 4;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  // Codes as produced by the keypad interface.
  localparam logic [1:0] OP_PLUS  = 2'd1;
  localparam logic [1:0] OP_MINUS = 2'd2;

  typedef struct packed {
    logic       dig;
    logic       op;
    logic       eq;
    logic [3:0] num;
    logic [1:0] opc;
  } key_evt_t;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add (carry) or subtract (borrow); purely combinational.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] bb;
  logic [4:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    bb   = {1'b0, b} + {4'b0, cin};
    // Always borrow ten up front so diff never goes negative.
    diff = {1'b0, a} + 5'd10 - bb;
    s    = '0;
    cout = 1'b0;
    if (sub) begin
      cout = ({1'b0, a} < bb);
      s    = cout ? diff[3:0] : 4'(diff - 5'd10);
    end else begin
      cout = (sum > 5'd9);
      s    = cout ? 4'(sum - 5'd10) : sum[3:0];
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Two-operand BCD calculator: builds A and B from key events, then adds or
// subtracts them one digit per cycle and presents the result for display.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_press,
  input  logic              is_number,
  input  logic              is_op,
  input  logic              is_eq,
  input  logic [3:0]        num_val,
  input  logic [1:0]        op_val,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic              disp_neg,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(NDIG);

  typedef logic [NDIG-1:0][3:0] bcd_t;

  logic [2:0]    state;
  logic          btn_q;
  bcd_t          a_r, b_r, r_r, x_r, y_r;
  logic [CW-1:0] cnt_a, cnt_b, cc;
  logic [1:0]    op;
  logic          carry, neg, ovf;
  logic          evt;
  key_evt_t      key;
  logic [IW-1:0] dig_idx;
  logic [3:0]    d_sum;
  logic          d_cout;

  function automatic bcd_t shift_in(input bcd_t v, input logic [3:0] d);
    bcd_t t;
    t    = v << 4;
    t[0] = d;
    return t;
  endfunction

  function automatic bcd_t one_digit(input logic [3:0] d);
    bcd_t t;
    t    = '0;
    t[0] = d;
    return t;
  endfunction

  function automatic logic [CW-1:0] sig_digits(input bcd_t v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NDIG; i++)
      if (v[i] != 4'd0) n = CW'(i + 1);
    return n;
  endfunction

  assign evt = btn_press & ~btn_q;

  always_comb begin
    key.dig = evt & is_number & (num_val <= 4'd9);
    key.op  = evt & is_op & ((op_val == OP_PLUS) || (op_val == OP_MINUS));
    key.eq  = evt & is_eq;
    key.num = num_val;
    key.opc = op_val;
  end

  // cc==0 is the operand-ordering cycle; cc=1..NDIG work on digit cc-1.
  assign dig_idx = IW'(cc - ONE);

  bcd_digit_addsub u_dig (
    .a    (x_r[dig_idx]),
    .b    (y_r[dig_idx]),
    .sub  (op == OP_MINUS),
    .cin  (carry),
    .s    (d_sum),
    .cout (d_cout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_A;
      btn_q <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      r_r   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      cc    <= '0;
      op    <= '0;
      carry <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      btn_q <= btn_press;
      case (state)
        S_A: begin
          if (key.dig) begin
            if (cnt_a < FULL && !(a_r == '0 && key.num == 4'd0)) begin
              a_r   <= shift_in(a_r, key.num);
              cnt_a <= cnt_a + ONE;
            end
          end else if (key.op) begin
            op    <= key.opc;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (key.dig) begin
            b_r   <= one_digit(key.num);
            cnt_b <= (key.num != 4'd0) ? ONE : '0;
            state <= S_B;
          end else if (key.op) begin
            op <= key.opc;
          end
        end
        S_B: begin
          if (key.dig) begin
            if (cnt_b < FULL && !(b_r == '0 && key.num == 4'd0)) begin
              b_r   <= shift_in(b_r, key.num);
              cnt_b <= cnt_b + ONE;
            end
          end else if (key.eq) begin
            cc    <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (cc == '0) begin
            // Subtract the smaller magnitude from the larger; sign kept apart.
            if (op == OP_MINUS && a_r < b_r) begin
              x_r <= b_r;
              y_r <= a_r;
              neg <= 1'b1;
            end else begin
              x_r <= a_r;
              y_r <= b_r;
              neg <= 1'b0;
            end
            carry <= 1'b0;
            cc    <= cc + ONE;
          end else begin
            r_r[dig_idx] <= d_sum;
            carry        <= d_cout;
            if (cc == FULL) begin
              ovf   <= (op == OP_PLUS) & d_cout;
              state <= S_RES;
            end else begin
              cc <= cc + ONE;
            end
          end
        end
        S_RES: begin
          if (key.dig) begin
            a_r   <= one_digit(key.num);
            cnt_a <= (key.num != 4'd0) ? ONE : '0;
            b_r   <= '0;
            r_r   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            cnt_b <= '0;
            op    <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
            state <= S_A;
          end else if (key.op && !neg && !ovf) begin
            a_r   <= r_r;
            cnt_a <= sig_digits(r_r);
            b_r   <= '0;
            cnt_b <= '0;
            op    <= key.opc;
            state <= S_OP;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  // Registered display mux: reflects the state one edge after it changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_A, S_OP:   disp_bcd <= a_r;
        S_B, S_CALC: disp_bcd <= b_r;
        default:     disp_bcd <= r_r;
      endcase
      disp_neg <= (state == S_RES) & neg;
      overflow <= ovf;
      busy     <= (state == S_CALC);
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: integer-valued calculator model feeds an
// expected-result queue drained by a monitor on each end of busy.
module tb_calc_ctrl;

  localparam int NDIG = 4;
  localparam int MAXV = 10 ** NDIG;
  localparam int M_A = 0, M_OP = 1, M_B = 2, M_RES = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_press = 1'b0, is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
  logic [3:0] num_val = '0;
  logic [1:0] op_val = '0;
  logic [4*NDIG-1:0] disp_bcd;
  logic disp_neg, overflow, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int val;
    bit neg;
    bit ovf;
  } res_t;
  res_t exp_q[$];

  int m_mode, m_a, m_b, m_r, m_op;
  bit m_neg, m_ovf;

  calc_ctrl #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_press (btn_press),
    .is_number (is_number),
    .is_op     (is_op),
    .is_eq     (is_eq),
    .num_val   (num_val),
    .op_val    (op_val),
    .disp_bcd  (disp_bcd),
    .disp_neg  (disp_neg),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_r = 0; m_op = 0;
    m_neg = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endfunction

  // kind: 0 digit, 1 operator, 2 equals, 3 no flag
  function automatic void model_key(input int kind, input int v);
    bit dig, opk, eqk;
    res_t e;
    dig = (kind == 0) && (v <= 9);
    opk = (kind == 1) && (v == 1 || v == 2);
    eqk = (kind == 2);
    case (m_mode)
      M_A:
        if (dig) begin
          if (m_a < MAXV / 10) m_a = m_a * 10 + v;
        end else if (opk) begin
          m_op = v; m_mode = M_OP;
        end
      M_OP:
        if (dig) begin
          m_b = v; m_mode = M_B;
        end else if (opk) m_op = v;
      M_B:
        if (dig) begin
          if (m_b < MAXV / 10) m_b = m_b * 10 + v;
        end else if (eqk) begin
          if (m_op == 1) begin
            m_r = (m_a + m_b) % MAXV; m_ovf = (m_a + m_b) >= MAXV; m_neg = 1'b0;
          end else begin
            m_neg = (m_a < m_b); m_r = m_neg ? m_b - m_a : m_a - m_b; m_ovf = 1'b0;
          end
          e.val = m_r; e.neg = m_neg; e.ovf = m_ovf;
          exp_q.push_back(e);
          m_mode = M_RES;
        end
      default:
        if (dig) begin
          m_a = v; m_b = 0; m_r = 0; m_neg = 1'b0; m_ovf = 1'b0; m_mode = M_A;
        end else if (opk && !m_neg && !m_ovf) begin
          m_a = m_r; m_op = v; m_mode = M_OP;
        end
    endcase
  endfunction

  task automatic check_disp();
    int v;
    v = (m_mode == M_B) ? m_b : (m_mode == M_RES) ? m_r : m_a;
    chk("disp_bcd", 32'(disp_bcd), 32'(to_bcd(v)));
    chk("disp_neg", 32'(disp_neg), 32'(m_mode == M_RES && m_neg));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic key(input int kind, input int v, input int hold, input int gap);
    @(negedge clk);
    btn_press = 1'b1;
    is_number = (kind == 0);
    is_op     = (kind == 1);
    is_eq     = (kind == 2);
    num_val   = 4'(v);
    op_val    = 2'(v);
    repeat (hold) @(negedge clk);
    btn_press = 1'b0; is_number = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    model_key(kind, v);
    repeat (gap) @(negedge clk);
    check_disp();
  endtask

  task automatic press(input int kind, input int v);
    key(kind, v, 2, (kind == 2) ? 12 : 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    btn_press = 1'b0; is_number = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_disp();
    reset = 1'b1;
  endtask

  // Each fall of busy presents a result; compare it with the oldest expectation.
  initial begin : monitor
    bit   prev;
    int   blen;
    res_t e;
    prev = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        blen = 0;
        prev = 1'b0;
      end else begin
        if (busy) blen++;
        else if (prev) begin
          if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("res_bcd", 32'(disp_bcd), 32'(to_bcd(e.val)));
            chk("res_neg", 32'(disp_neg), 32'(e.neg));
            chk("res_ovf", 32'(overflow), 32'(e.ovf));
            chk("busy_cycles", 32'(blen), 32'(NDIG + 1));
          end
          blen = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : stim
    int r, kind, v, hold, gap;
    model_reset();
    repeat (3) @(negedge clk);
    check_disp();
    reset = 1'b1;

    // 12 + 34
    press(0, 1); press(0, 2); press(1, 1); press(0, 3); press(0, 4); press(2, 0);
    // 5 - 8, then a refused chain
    press(0, 5); press(1, 2); press(0, 8); press(2, 0); press(1, 1);
    // 9999 + 1 overflows, then a fresh digit
    press(0, 9); press(0, 9); press(0, 9); press(0, 9); press(1, 1); press(0, 1); press(2, 0);
    press(0, 7);

    // digit limit and held keys
    do_reset();
    press(0, 1); press(0, 2); press(0, 3); press(0, 4); press(0, 5);
    press(1, 1);
    key(0, 6, 20, 3);
    key(0, 2, 20, 3);
    press(2, 0);

    // chaining
    press(0, 7); press(1, 1); press(0, 3); press(2, 0);
    press(1, 1); press(0, 5); press(2, 0);

    // reset during the second calculation cycle
    do_reset();
    press(0, 6); press(1, 1); press(0, 7);
    @(negedge clk);
    btn_press = 1'b1; is_eq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    btn_press = 1'b0; is_eq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_mid_calc", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_disp();
    reset = 1'b1;
    press(0, 2);

    // random key streams, including invalid keys and long holds
    for (int n = 0; n < 300; n++) begin
      r    = int'($urandom_range(0, 99));
      hold = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 4));
      gap  = int'($urandom_range(2, 5));
      v    = 0;
      if (r < 50)      begin kind = 0; v = int'($urandom_range(0, 9)); end
      else if (r < 58) begin kind = 0; v = int'($urandom_range(10, 15)); end
      else if (r < 78) begin kind = 1; v = int'($urandom_range(0, 3)); end
      else if (r < 95) begin kind = 2; gap = 12; end
      else             begin kind = 3; end
      key(kind, v, hold, gap);
    end

    repeat (10) @(negedge clk);
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
